cache_assoc: RTL

CACHE_ASSOC -- requirements
Module: cache_assoc

---
 rtl/cache_assoc_pkg.sv | 67 ++++++
 rtl/cache_assoc_plru.sv | 34 +++
 rtl/cache_assoc.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/cache_assoc_pkg.sv
// Shared types, derived widths and tree-PLRU helpers for cache_assoc.
// PLRU trees use heap numbering: node 1 is the root, children are 2n and 2n+1.
package cache_assoc_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVICT,
    S_REFILL
  } state_t;

  localparam int PLRU_W = 8;

  function automatic int byte_bits(int arch);
    return $clog2(arch / 8);
  endfunction

  function automatic int word_bits(int line, int arch);
    return $clog2(line / arch);
  endfunction

  function automatic int set_bits(int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_bits(int arch, int line, int sets);
    return arch - $clog2(sets) - $clog2(line / 8);
  endfunction

  // A node bit of 1 means the LRU side is the right subtree.
  function automatic logic [PLRU_W-1:0] plru_touch(
    logic [PLRU_W-1:0] bits,
    logic [2:0]        way,
    int                lg
  );
    int   node;
    logic dir;
    node = 1;
    for (int i = 0; i < 3; i++) begin
      if (i < lg) begin
        dir        = way[lg-1-i];
        bits[node] = ~dir;
        node       = 2 * node + int'(dir);
      end
    end
    return bits;
  endfunction

  function automatic logic [2:0] plru_victim(
    logic [PLRU_W-1:0] bits,
    int                lg
  );
    int         node;
    logic       dir;
    logic [2:0] way;
    node = 1;
    way  = '0;
    for (int i = 0; i < 3; i++) begin
      if (i < lg) begin
        dir  = bits[node];
        way  = {way[1:0], dir};
        node = 2 * node + int'(dir);
      end
    end
    return way;
  endfunction

endpackage

// File: rtl/cache_assoc_plru.sv
// Per-set tree-PLRU state with a touch port and a victim lookup.
// A single way needs no tree, so the victim is then constant 0.
module cache_plru #(
  parameter int WAYS = 2,
  parameter int SETS = 4,
  parameter int SW   = 2,
  parameter int WW   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_touch,
  input  logic [SW-1:0] i_touch_set,
  input  logic [WW-1:0] i_touch_way,
  input  logic [SW-1:0] i_set,
  output logic [WW-1:0] o_victim
);
  import cache_assoc_pkg::*;

  localparam int LG = $clog2(WAYS);

  logic [PLRU_W-1:0] r_bits [SETS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) r_bits[s] <= '0;
    end else if (i_touch) begin
      r_bits[i_touch_set] <= plru_touch(
        r_bits[i_touch_set], 3'(i_touch_way), LG);
    end
  end

  assign o_victim = WW'(plru_victim(r_bits[i_set], LG));

endmodule

// File: rtl/cache_assoc.sv
// Set-associative write-back cache, blocking, one access at a time.
// Define CACHE_ASSOC_STATS_EN to add hit/miss/writeback counters.
module cache_assoc #(
  parameter int ARCH_BITS = 32,
  parameter int WAYS      = 2,
  parameter int SETS      = 4,
  parameter int LINE_SIZE = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 we,
  input  logic                 byte_en,
  input  logic [ARCH_BITS-1:0] addr,
  input  logic [ARCH_BITS-1:0] wdata,
  output logic [ARCH_BITS-1:0] rdata,
  output logic                 ack,
  output logic [ARCH_BITS-1:0] mem_addr,
  output logic                 mem_req,
  input  logic [LINE_SIZE-1:0] mem_data,
  input  logic                 mem_valid,
  output logic [ARCH_BITS-1:0] wb_addr,
  output logic [LINE_SIZE-1:0] wb_line,
  output logic                 wb_req,
  input  logic                 wb_ack
`ifdef CACHE_ASSOC_STATS_EN
  ,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt,
  output logic [31:0]          wb_cnt
`endif
);
  import cache_assoc_pkg::*;

  localparam int BB  = byte_bits(ARCH_BITS);
  localparam int WB  = word_bits(LINE_SIZE, ARCH_BITS);
  localparam int SB  = set_bits(SETS);
  localparam int TB  = tag_bits(ARCH_BITS, LINE_SIZE, SETS);
  localparam int OB  = WB + BB;
  localparam int WW  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int WIW = (WB > 0) ? WB : 1;
  localparam int BIW = (BB > 0) ? BB : 1;

  state_t               r_state;
  logic [SETS-1:0]      r_valid [WAYS];
  logic [SETS-1:0]      r_dirty [WAYS];
  logic [TB-1:0]        r_tag   [WAYS][SETS];
  logic [LINE_SIZE-1:0] r_data  [WAYS][SETS];
  logic [WW-1:0]        r_vway;
  logic [SB-1:0]        r_vset;
  logic [TB-1:0]        r_mtag;

  logic [TB-1:0]        w_tag;
  logic [SB-1:0]        w_set;
  logic [WIW-1:0]       w_widx;
  logic [BIW-1:0]       w_bidx;
  logic [WAYS-1:0]      w_hitv;
  logic [WW-1:0]        w_hway;
  logic                 w_hit;
  logic [WW-1:0]        w_inv_way;
  logic                 w_any_inv;
  logic [WW-1:0]        w_plru_way;
  logic [WW-1:0]        w_victim;
  logic                 w_vdirty;
  logic                 w_install;
  logic [LINE_SIZE-1:0] w_line;
  logic [LINE_SIZE-1:0] w_wline;
  logic [ARCH_BITS-1:0] w_word;
  logic [7:0]           w_byte;

  assign w_tag  = addr[ARCH_BITS-1 -: TB];
  assign w_set  = addr[OB +: SB];
  assign w_widx = WIW'((addr >> BB) & ARCH_BITS'(LINE_SIZE / ARCH_BITS - 1));
  assign w_bidx = BIW'(addr & ARCH_BITS'(ARCH_BITS / 8 - 1));

  always_comb begin
    w_hitv    = '0;
    w_hway    = '0;
    w_inv_way = '0;
    w_any_inv = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      w_hitv[w] = r_valid[w][w_set] && (r_tag[w][w_set] == w_tag);
      if (w_hitv[w]) w_hway = WW'(w);
      if (!r_valid[w][w_set]) begin
        w_inv_way = WW'(w);
        w_any_inv = 1'b1;
      end
    end
  end

  assign w_victim  = w_any_inv ? w_inv_way : w_plru_way;
  assign w_vdirty  = r_valid[w_victim][w_set] && r_dirty[w_victim][w_set];
  assign w_hit     = (r_state == S_IDLE) && req && (|w_hitv);
  assign w_install = (r_state == S_REFILL) && mem_valid;

  assign w_line = r_data[w_hway][w_set];
  assign w_word = w_line[w_widx*ARCH_BITS +: ARCH_BITS];
  assign w_byte = w_word[w_bidx*8 +: 8];

  always_comb begin
    w_wline = w_line;
    if (byte_en) w_wline[w_widx*ARCH_BITS + w_bidx*8 +: 8] = wdata[7:0];
    else         w_wline[w_widx*ARCH_BITS +: ARCH_BITS]    = wdata;
  end

  assign ack   = w_hit;
  assign rdata = !w_hit ? '0
               : byte_en ? {{(ARCH_BITS-8){w_byte[7]}}, w_byte}
               : w_word;

  assign mem_req  = (r_state == S_REFILL);
  assign wb_req   = (r_state == S_EVICT);
  assign mem_addr = ARCH_BITS'({r_mtag, r_vset}) << OB;
  assign wb_addr  = ARCH_BITS'({r_tag[r_vway][r_vset], r_vset}) << OB;
  assign wb_line  = r_data[r_vway][r_vset];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_vway  <= '0;
      r_vset  <= '0;
      r_mtag  <= '0;
      for (int w = 0; w < WAYS; w++) begin
        r_valid[w] <= '0;
        r_dirty[w] <= '0;
      end
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_hit && we) begin
            r_dirty[w_hway][w_set] <= 1'b1;
          end else if (req && !w_hit) begin
            r_vway  <= w_victim;
            r_vset  <= w_set;
            r_mtag  <= w_tag;
            r_state <= w_vdirty ? S_EVICT : S_REFILL;
          end
        end
        S_EVICT: begin
          if (wb_ack) begin
            r_valid[r_vway][r_vset] <= 1'b0;
            r_dirty[r_vway][r_vset] <= 1'b0;
            r_state                 <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (mem_valid) begin
            r_valid[r_vway][r_vset] <= 1'b1;
            r_dirty[r_vway][r_vset] <= 1'b0;
            r_state                 <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Line storage and tags carry no reset.
  always_ff @(posedge clk) begin
    if (w_install) begin
      r_data[r_vway][r_vset] <= mem_data;
      r_tag[r_vway][r_vset]  <= r_mtag;
    end else if (w_hit && we) begin
      r_data[w_hway][w_set] <= w_wline;
    end
  end

  cache_plru #(
    .WAYS(WAYS),
    .SETS(SETS),
    .SW  (SB),
    .WW  (WW)
  ) u_plru (
    .clk        (clk),
    .rst        (rst),
    .i_touch    (w_hit | w_install),
    .i_touch_set(w_hit ? w_set : r_vset),
    .i_touch_way(w_hit ? w_hway : r_vway),
    .i_set      (w_set),
    .o_victim   (w_plru_way)
  );

`ifdef CACHE_ASSOC_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (w_hit && hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
      if ((r_state == S_IDLE) && req && !w_hit && miss_cnt != '1)
        miss_cnt <= miss_cnt + 32'd1;
      if ((r_state == S_EVICT) && wb_ack && wb_cnt != '1)
        wb_cnt <= wb_cnt + 32'd1;
    end
  end
`endif

endmodule
